// File: rtl/interface_demux.sv
// rtl/interface_demux.sv - egress distributor from backend stream FIFOs to per-port TX FIFOs
//
// Pops one frame descriptor, waits until every destination port can absorb a
// maximum-size frame, then streams len payload bytes to all destinations at
// once (multicast) and finally writes the TX descriptor to each of them.
// Errored or mask-0 frames are popped and discarded so the streams stay aligned.
//
// Ports:
//   clk_sys, rstn_sys      system clock, async active-low reset
//   ptr_sfifo_empty/rd/dout backend descriptor FIFO {err, mask[3:0], len[10:0]}
//   sfifo_rd/dout           backend payload FIFO (8-bit)
//   tx_data_fifo_afull[3:0] per-port "less than one max frame of space"
//   tx_ptr_fifo_full[3:0]   per-port TX descriptor FIFO full
//   tx_data_fifo_wr/din     per-port byte strobe, shared byte
//   tx_ptr_fifo_wr/din      per-port descriptor strobe, shared {5'b0, len}

module interface_demux (
  input  logic        clk_sys,
  input  logic        rstn_sys,
  input  logic        ptr_sfifo_empty,
  output logic        ptr_sfifo_rd,
  input  logic [15:0] ptr_sfifo_dout,
  output logic        sfifo_rd,
  input  logic [7:0]  sfifo_dout,
  input  logic [3:0]  tx_data_fifo_afull,
  input  logic [3:0]  tx_ptr_fifo_full,
  output logic [3:0]  tx_data_fifo_wr,
  output logic [7:0]  tx_data_fifo_din,
  output logic [3:0]  tx_ptr_fifo_wr,
  output logic [15:0] tx_ptr_fifo_din
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRD, S_PCAP, S_WAIT, S_DATA, S_FLUSH0, S_FLUSH1, S_PWR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] len;
  logic [10:0] cnt;
  logic [3:0]  mask;
  logic        drop;
  logic        rd_d;
  logic        ready;

  // Every destination must have room for a whole frame; only looked at in WAIT.
  assign ready = ((tx_data_fifo_afull | tx_ptr_fifo_full) & mask) == 4'b0000;

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ptr_sfifo_rd    = 1'b0;
    sfifo_rd        = 1'b0;
    tx_ptr_fifo_wr  = 4'b0000;
    tx_ptr_fifo_din = 16'h0000;
    case (state)
      S_IDLE: begin
        if (!ptr_sfifo_empty) state_nxt = S_PRD;
      end
      S_PRD: begin
        ptr_sfifo_rd = 1'b1;
        state_nxt    = S_PCAP;
      end
      S_PCAP: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (len == 11'd0)       state_nxt = S_IDLE;
        else if (drop || ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        sfifo_rd = 1'b1;
        if (cnt == len) state_nxt = S_FLUSH0;
      end
      // Two cycles let the last popped byte travel through the write register.
      S_FLUSH0: begin
        state_nxt = S_FLUSH1;
      end
      S_FLUSH1: begin
        state_nxt = drop ? S_IDLE : S_PWR;
      end
      S_PWR: begin
        tx_ptr_fifo_wr  = mask;
        tx_ptr_fifo_din = {5'b00000, len};
        state_nxt       = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      len              <= 11'd0;
      mask             <= 4'b0000;
      drop             <= 1'b0;
      cnt              <= 11'd0;
      rd_d             <= 1'b0;
      tx_data_fifo_wr  <= 4'b0000;
      tx_data_fifo_din <= 8'h00;
    end else begin
      if (state == S_PCAP) begin
        len  <= ptr_sfifo_dout[10:0];
        mask <= ptr_sfifo_dout[14:11];
        drop <= ptr_sfifo_dout[15] | (ptr_sfifo_dout[14:11] == 4'b0000);
      end
      // Counter holds at len on the last byte so len = 2047 never wraps.
      if (state == S_WAIT) begin
        cnt <= 11'd1;
      end else if (state == S_DATA && cnt != len) begin
        cnt <= cnt + 11'd1;
      end
      // Payload arrives one cycle after the pop; register it toward all ports.
      rd_d <= sfifo_rd;
      if (rd_d) begin
        tx_data_fifo_din <= sfifo_dout;
        tx_data_fifo_wr  <= drop ? 4'b0000 : mask;
      end else begin
        tx_data_fifo_wr  <= 4'b0000;
      end
    end
  end

endmodule
